// File: rtl/ccu_pkg.sv
// ccu_pkg: shared FSM state type, default widths and max-count helper for the coincidence window counter
package ccu_pkg;
  typedef enum logic {IDLE, COUNT} state_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_WIN_W  = 32;
  function automatic logic [63:0] max_count(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating per-channel pulse counter with sticky saturation flag
// Ports: clk, rst_n (async low), clear (restart at 0 on this edge), inc (one pulse),
//   count/sat = value and flag after this edge's increment, before any clear.
module sat_counter import ccu_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(max_count(CNT_W));
  logic [CNT_W-1:0] count_q;
  logic             sat_q;
  logic [CNT_W:0]   sum;
  assign sum   = {1'b0, count_q} + (CNT_W+1)'(inc);
  assign count = sum[CNT_W] ? MAX : sum[CNT_W-1:0];
  assign sat   = sat_q | sum[CNT_W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= clear ? '0 : count;
      sat_q   <= clear ? 1'b0 : sat;
    end
  end
endmodule

// File: rtl/coincidence_window_counter.sv
// coincidence_window_counter: counts coincidence pulses per channel over back-to-back gate windows, emits frames via valid/ready
// Ports: clk, rst_n (async low), enable, win_cycles, pulse_in[NUM_CH], out_ready in;
//   out_valid, out_counts[NUM_CH*CNT_W], out_sat[NUM_CH], out_dropped, busy out.
// Macro EDGE_DETECT_EN: count rising edges of pulse_in (one extra cycle of latency) instead of raw levels.
module coincidence_window_counter import ccu_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [WIN_W-1:0]        win_cycles,
  input  logic [NUM_CH-1:0]       pulse_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*CNT_W-1:0] out_counts,
  output logic [NUM_CH-1:0]       out_sat,
  output logic                    out_dropped,
  output logic                    busy
);
  state_t                    state_q, state_d;
  logic [WIN_W-1:0]          win_left_q, win_left_d, win_load;
  logic [NUM_CH-1:0]         pulse, sat_nxt, out_sat_q;
  logic [NUM_CH*CNT_W-1:0]   cnt_nxt, out_counts_q;
  logic                      out_valid_q, out_valid_d, out_dropped_q, drop_q, drop_d;
  logic                      run, last, clear, accept, overrun;
`ifdef EDGE_DETECT_EN
  logic [NUM_CH-1:0] prev_q, edge_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= pulse_in;
      edge_q <= pulse_in & ~prev_q;
    end
  end
  assign pulse = edge_q;
`else
  assign pulse = pulse_in;
`endif
  assign run      = (state_q == COUNT) && enable;
  assign last     = run && (win_left_q == '0);
  // counters restart on the final sample so the next cycle's pulse lands in the new window
  assign clear    = !run || last;
  assign win_load = (win_cycles == '0) ? '0 : win_cycles - WIN_W'(1);
  assign accept   = out_valid_q && out_ready;
  assign overrun  = last && out_valid_q && !out_ready;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .inc   (pulse[i]),
      .count (cnt_nxt[i*CNT_W +: CNT_W]),
      .sat   (sat_nxt[i])
    );
  end
  always_comb begin
    state_d     = enable ? COUNT : IDLE;
    win_left_d  = clear ? win_load : win_left_q - WIN_W'(1);
    drop_d      = overrun ? 1'b1 : accept ? 1'b0 : drop_q;
    out_valid_d = last || (out_valid_q && !out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      win_left_q    <= '0;
      out_valid_q   <= 1'b0;
      out_counts_q  <= '0;
      out_sat_q     <= '0;
      out_dropped_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_left_q  <= win_left_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      if (last) begin
        out_counts_q  <= cnt_nxt;
        out_sat_q     <= sat_nxt;
        out_dropped_q <= drop_d;
      end
    end
  end
  assign out_valid   = out_valid_q;
  assign out_counts  = out_counts_q;
  assign out_sat     = out_sat_q;
  assign out_dropped = out_dropped_q;
  assign busy        = (state_q == COUNT);
endmodule

// File: tb/tb_coincidence_window_counter.sv
// tb_coincidence_window_counter: table, directed and random checks against a window-level reference model
module tb_coincidence_window_counter;
  localparam int NC = 4, CW = 4, WW = 8, MAXC = 15;
`ifdef EDGE_DETECT_EN
  localparam bit ED = 1'b1;
`else
  localparam bit ED = 1'b0;
`endif
  logic           clk = 1'b0, rst_n = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic [WW-1:0]  win_cycles = '0;
  logic [NC-1:0]  pulse_in = '0;
  logic           out_valid, out_dropped, busy;
  logic [NC*CW-1:0] out_counts;
  logic [NC-1:0]  out_sat;
  int checks = 0, errors = 0;
  bit m_run, m_valid, m_drop, m_dout;
  int m_left;
  int m_cnt[NC], m_frame[NC];
  logic [NC-1:0] m_fsat, m_prev, m_edge;
  typedef struct { bit en; int wc; logic [NC-1:0] p; bit rdy; bit ev; bit eb; int ec0; } vec_t;
  vec_t tbl[12];

  coincidence_window_counter #(.NUM_CH(NC), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .win_cycles(win_cycles), .pulse_in(pulse_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_counts(out_counts), .out_sat(out_sat),
    .out_dropped(out_dropped), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_drop = 0; m_dout = 0; m_left = 0;
    m_fsat = '0; m_prev = '0; m_edge = '0;
    for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_frame[c] = 0; end
  endtask

  function automatic int wlen(input logic [WW-1:0] w);
    return (w == 0) ? 1 : int'(w);
  endfunction

  task automatic model_step();
    bit acc, lst, ovr;
    logic [NC-1:0] eff;
    if (!rst_n) begin model_reset(); return; end
    acc = m_valid && out_ready;
    lst = m_run && enable && m_left == 0;
    ovr = lst && m_valid && !out_ready;
    eff = ED ? m_edge : pulse_in;
    m_edge = pulse_in & ~m_prev;
    m_prev = pulse_in;
    if (m_run && enable) begin
      for (int c = 0; c < NC; c++) m_cnt[c] += int'(eff[c]);
      if (lst) begin
        for (int c = 0; c < NC; c++) begin
          m_frame[c] = (m_cnt[c] > MAXC) ? MAXC : m_cnt[c];
          m_fsat[c] = m_cnt[c] > MAXC;
          m_cnt[c] = 0;
        end
        m_left = wlen(win_cycles) - 1;
      end else m_left--;
    end else begin
      for (int c = 0; c < NC; c++) m_cnt[c] = 0;
      m_run = enable;
      m_left = wlen(win_cycles) - 1;
    end
    m_drop = ovr ? 1'b1 : acc ? 1'b0 : m_drop;
    if (lst) m_dout = m_drop;
    m_valid = lst || (m_valid && !out_ready);
  endtask

  task automatic compare_all();
    logic [NC*CW-1:0] ev;
    for (int c = 0; c < NC; c++) ev[c*CW +: CW] = CW'(m_frame[c]);
    check("valid", out_valid, m_valid);
    check("busy", busy, m_run);
    check("counts", out_counts, ev);
    check("sat", out_sat, m_fsat);
    check("dropped", out_dropped, m_dout);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n, input logic [NC-1:0] p);
    pulse_in = p;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic go_idle();
    enable = 0;
    ticks(2, '0);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 12; i++)
      tbl[i] = '{en: 1'b1, wc: 10, p: NC'((i == 1 || i == 5 || i == 10) ? 1 : 0), rdy: 1'b1,
                 ev: (i == 10), eb: 1'b1, ec0: (i >= 10) ? (ED ? 2 : 3) : 0};
    ticks(2, '0);
    check("reset_valid", out_valid, 1'b0);
    check("reset_counts", out_counts, '0);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      enable = tbl[i].en; win_cycles = WW'(tbl[i].wc); pulse_in = tbl[i].p; out_ready = tbl[i].rdy;
      tick();
      check("tbl_valid", out_valid, tbl[i].ev);
      check("tbl_busy", busy, tbl[i].eb);
      check("tbl_ch0", out_counts[CW-1:0], CW'(tbl[i].ec0));
    end
    go_idle();
    win_cycles = 5; enable = 1; tick();
    ticks(4, '0);
    ticks(1, 4'b0100);
    check("t2_w1_ch2", out_counts[2*CW +: CW], ED ? 0 : 1);
    ticks(1, 4'b0100);
    ticks(4, '0);
    check("t2_w2_ch2", out_counts[2*CW +: CW], 1);
    go_idle();
    win_cycles = 20; enable = 1; tick();
    ticks(20, 4'b1000);
    check("t3_ch3", out_counts[3*CW +: CW], ED ? 1 : 15);
    check("t3_sat3", out_sat[3], ED ? 0 : 1);
    go_idle();
    win_cycles = 4; out_ready = 0; enable = 1; tick();
    ticks(12, 4'b0001);
    check("t4_valid", out_valid, 1'b1);
    check("t4_dropped", out_dropped, 1'b1);
    out_ready = 1; ticks(1, '0);
    check("t4_accept", out_valid, 1'b0);
    out_ready = 0; ticks(3, '0);
    check("t4_next_valid", out_valid, 1'b1);
    check("t4_next_dropped", out_dropped, 1'b0);
    ticks(2, 4'b0011);
    enable = 0; ticks(1, 4'b0011);
    check("t5_idle", busy, 1'b0);
    ticks(5, 4'b0011);
    check("t5_held", out_valid, 1'b1);
    #3 rst_n = 0;
    #1 model_reset();
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_counts", out_counts, '0);
    compare_all();
    tick();
    rst_n = 1; enable = 1; out_ready = 1; win_cycles = 3;
    tick();
    check("t5_restart", busy, 1'b1);
    ticks(3, 4'b0101);
    check("t5_frame", out_valid, 1'b1);
    go_idle();
    win_cycles = 8; enable = 1; tick();
    ticks(6, 4'b0001);
    ticks(2, '0);
    check("t6_ch0", out_counts[CW-1:0], ED ? 1 : 6);
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom % 25) != 0;
      if (($urandom % 8) == 0) win_cycles = WW'($urandom % 13);
      pulse_in = NC'($urandom);
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
